// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: parametrised ID->EX pipeline register with valid tracking, stall, flush and bubble gating.
//
// Ports:
//   clk            pipeline clock, rising edge
//   reset          synchronous active-high reset, clears every output
//   stall          hold current contents
//   flush          load a bubble on the next edge
//   valid_in       decode stage presents a real instruction
//   reg_data1_in   rs read data          -> reg_data1_out
//   reg_data2_in   rt read data          -> reg_data2_out
//   ext_in         extended immediate    -> ext_out
//   rs_in/rt_in/rd_in  register specifiers -> rs_out/rt_out/rd_out
//   alu_ctl_in     ALU operation         -> alu_ctl_out
//   ctrl_in        {RegDst, MemWrite, MemtoReg, RegWrite, ALUSrc} -> ctrl_out
//   valid_out      EX stage holds a real instruction
//   bubble_cnt     saturating count of bubbles loaded
//
// Build option: define ID_EX_BUBBLE_CNT_EN to enable the bubble counter;
// otherwise bubble_cnt is tied to zero.
module id_ex_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUCTL_W = 6,
    parameter int CTRL_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   reg_data1_in,
    input  logic [DATA_W-1:0]   reg_data2_in,
    input  logic [DATA_W-1:0]   ext_in,
    input  logic [RADDR_W-1:0]  rs_in,
    input  logic [RADDR_W-1:0]  rt_in,
    input  logic [RADDR_W-1:0]  rd_in,
    input  logic [ALUCTL_W-1:0] alu_ctl_in,
    input  logic [CTRL_W-1:0]   ctrl_in,
    output logic                valid_out,
    output logic [DATA_W-1:0]   reg_data1_out,
    output logic [DATA_W-1:0]   reg_data2_out,
    output logic [DATA_W-1:0]   ext_out,
    output logic [RADDR_W-1:0]  rs_out,
    output logic [RADDR_W-1:0]  rt_out,
    output logic [RADDR_W-1:0]  rd_out,
    output logic [ALUCTL_W-1:0] alu_ctl_out,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [15:0]         bubble_cnt
);

    // A bubble is loaded on flush, or on an unstalled edge with no real instruction.
    // Flush overrides stall so the stage always empties when both are asserted.
    logic bubble;
    assign bubble = flush | (~stall & ~valid_in);

    // Bubbles clear every field, so no control bit or specifier can leak into EX/forwarding.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_out     <= 1'b0;
            reg_data1_out <= '0;
            reg_data2_out <= '0;
            ext_out       <= '0;
            rs_out        <= '0;
            rt_out        <= '0;
            rd_out        <= '0;
            alu_ctl_out   <= '0;
            ctrl_out      <= '0;
        end else if (!stall) begin
            valid_out     <= 1'b1;
            reg_data1_out <= reg_data1_in;
            reg_data2_out <= reg_data2_in;
            ext_out       <= ext_in;
            rs_out        <= rs_in;
            rt_out        <= rt_in;
            rd_out        <= rd_in;
            alu_ctl_out   <= alu_ctl_in;
            ctrl_out      <= ctrl_in;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturating counter; stall-hold edges are not bubbles and do not count.
    always_ff @(posedge clk) begin
        if (reset)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: self-checking bench for id_ex_stage_reg against a behavioural model.
//
// Drives directed scenarios followed by random control/data traffic; the model
// applies the reset > flush > stall > load rules to an expected stage record.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in;
    logic [31:0] reg_data1_in, reg_data2_in, ext_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [5:0]  alu_ctl_in;
    logic [4:0]  ctrl_in;
    logic        valid_out;
    logic [31:0] reg_data1_out, reg_data2_out, ext_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [5:0]  alu_ctl_out;
    logic [4:0]  ctrl_out;
    logic [15:0] bubble_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        v;
        logic [31:0] d1, d2, ext;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  alu;
        logic [4:0]  ctrl;
    } stage_t;

    stage_t m;
    stage_t empty;
    int     m_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .reg_data1_in(reg_data1_in), .reg_data2_in(reg_data2_in), .ext_in(ext_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .alu_ctl_in(alu_ctl_in), .ctrl_in(ctrl_in),
        .valid_out(valid_out),
        .reg_data1_out(reg_data1_out), .reg_data2_out(reg_data2_out), .ext_out(ext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .alu_ctl_out(alu_ctl_out), .ctrl_out(ctrl_out),
        .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rnd_in();
        reg_data1_in = $urandom;
        reg_data2_in = $urandom;
        ext_in       = $urandom;
        rs_in        = 5'($urandom);
        rt_in        = 5'($urandom);
        rd_in        = 5'($urandom);
        alu_ctl_in   = 6'($urandom);
        ctrl_in      = 5'($urandom);
    endtask

    // Model of one edge: what the stage should contain given the controls.
    task automatic model_edge();
        logic is_bubble;
        is_bubble = flush || (!stall && !valid_in);
        if (reset) begin
            m = empty;
            m_cnt = 0;
        end else begin
            if (is_bubble)
                m = empty;
            else if (!stall)
                m = '{1'b1, reg_data1_in, reg_data2_in, ext_in, rs_in, rt_in, rd_in, alu_ctl_in, ctrl_in};
`ifdef ID_EX_BUBBLE_CNT_EN
            if (is_bubble && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
        end
    endtask

    task automatic check_all(input bit full);
        if (full) begin
            chk("valid_out", {31'b0, valid_out}, {31'b0, m.v});
            chk("reg_data1_out", reg_data1_out, m.d1);
            chk("reg_data2_out", reg_data2_out, m.d2);
            chk("ext_out", ext_out, m.ext);
            chk("rs_out", {27'b0, rs_out}, {27'b0, m.rs});
            chk("rt_out", {27'b0, rt_out}, {27'b0, m.rt});
            chk("rd_out", {27'b0, rd_out}, {27'b0, m.rd});
            chk("alu_ctl_out", {26'b0, alu_ctl_out}, {26'b0, m.alu});
            chk("ctrl_out", {27'b0, ctrl_out}, {27'b0, m.ctrl});
            chk("bubble_inv", {27'b0, (valid_out ? 5'b0 : ctrl_out)}, 32'b0);
        end
        chk("bubble_cnt", {16'b0, bubble_cnt}, 32'(m_cnt));
    endtask

    task automatic cyc(input bit full = 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        check_all(full);
    endtask

    task automatic ctl(input logic r, input logic s, input logic f, input logic v);
        reset = r; stall = s; flush = f; valid_in = v;
    endtask

    initial begin
        empty = '{1'b0, 32'b0, 32'b0, 32'b0, 5'b0, 5'b0, 5'b0, 6'b0, 5'b0};
        m = empty;
        m_cnt = 0;
        rnd_in();
        ctl(1, 0, 0, 1);
        cyc(); cyc();

        // Reset then load
        ctl(0, 0, 0, 1);
        rnd_in(); reg_data1_in = 32'h1234_5678; rd_in = 5'd9; ctrl_in = 5'b00110;
        cyc();
        chk("load_d1_direct", reg_data1_out, 32'h1234_5678);
        chk("load_ctrl_direct", {27'b0, ctrl_out}, 32'h6);

        // Stall hold: A loaded, B presented during 3 stall cycles
        rnd_in(); alu_ctl_in = 6'h20;
        cyc();
        ctl(0, 1, 0, 1);
        rnd_in(); alu_ctl_in = 6'h22;
        cyc(); cyc(); cyc();
        chk("stall_hold_alu", {26'b0, alu_ctl_out}, 32'h20);
        ctl(0, 0, 0, 1);
        cyc();
        chk("stall_release_alu", {26'b0, alu_ctl_out}, 32'h22);

        // Flush with a valid stage holding ctrl 01010
        rnd_in(); ctrl_in = 5'b01010;
        cyc();
        ctl(0, 0, 1, 1); rnd_in();
        cyc();
        chk("flush_valid", {31'b0, valid_out}, 32'b0);

        // Priority: stall+flush -> bubble; reset with stall -> empty
        ctl(0, 0, 0, 1); rnd_in(); cyc();
        ctl(0, 1, 1, 1); rnd_in(); cyc();
        ctl(0, 0, 0, 1); rnd_in(); cyc();
        ctl(1, 1, 0, 1); rnd_in(); cyc();
        chk("reset_in_stall", {31'b0, valid_out}, 32'b0);

        // Input bubble
        ctl(0, 0, 0, 0); rnd_in(); ctrl_in = 5'b11111; rd_in = 5'd31;
        cyc();
        chk("input_bubble_rd", {27'b0, rd_out}, 32'b0);

        // 5 flushes + 2 invalid loads interleaved with 3 stalls after a reset
        ctl(1, 0, 0, 1); cyc();
        ctl(0, 0, 1, 1); rnd_in(); cyc();
        ctl(0, 1, 0, 1); rnd_in(); cyc();
        ctl(0, 0, 1, 0); rnd_in(); cyc();
        ctl(0, 0, 0, 0); rnd_in(); cyc();
        ctl(0, 1, 0, 0); rnd_in(); cyc();
        ctl(0, 0, 1, 1); rnd_in(); cyc();
        ctl(0, 0, 0, 0); rnd_in(); cyc();
        ctl(0, 1, 0, 1); rnd_in(); cyc();
        ctl(0, 1, 1, 1); rnd_in(); cyc();
        ctl(0, 0, 1, 0); rnd_in(); cyc();
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("bubble_cnt_seven", {16'b0, bubble_cnt}, 32'd7);
`else
        chk("bubble_cnt_tied", {16'b0, bubble_cnt}, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ctl($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
            rnd_in();
            cyc();
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Saturation
        ctl(1, 0, 0, 1); cyc();
        ctl(0, 0, 1, 1);
        for (int i = 0; i < 65540; i++) cyc(1'b0);
        chk("bubble_cnt_sat", {16'b0, bubble_cnt}, 32'hFFFF);
        ctl(0, 1, 0, 0); cyc();
        ctl(1, 0, 0, 1); cyc();
        chk("bubble_cnt_reset", {16'b0, bubble_cnt}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
